// File: rtl/rom_addr_sequencer.sv
// rtl/rom_addr_sequencer.sv - pattern ROM address sequencer pacing serializer word loads
//
// Steps addr from FIRST_ADDR to LAST_ADDR. Each word gets one load pulse,
// then the block waits for word_done before moving to the next address.
// A single start pulse runs a whole pass. With loop set, the pass repeats.
//
// Optional feature macro: ADDR_SEQ_TIMEOUT_EN. When it is defined, a WAIT
// watchdog of TIMEOUT cycles is added and drives timeout_err.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous reset, active-high
//   start        begin a pass (sampled only in IDLE)
//   stop         graceful stop request (sampled only while busy)
//   loop         wrap to FIRST_ADDR after LAST_ADDR (sampled at the LAST_ADDR boundary)
//   word_done    serializer finished current word (honoured only in WAIT)
//   addr         ROM address
//   load         one-cycle pulse, serializer captures ROM data at addr
//   busy         high in LOAD and WAIT
//   pass_done    one-cycle pulse when the word at LAST_ADDR completes
//   word_count   words completed in the current pass
//   timeout_err  sticky watchdog error (always 0 without ADDR_SEQ_TIMEOUT_EN)

module rom_addr_sequencer #(
  parameter int ADDR_W     = 5,
  parameter int FIRST_ADDR = 0,
  parameter int LAST_ADDR  = 31,
  parameter int TIMEOUT    = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
  input  logic              word_done,
  output logic [ADDR_W-1:0] addr,
  output logic              load,
  output logic              busy,
  output logic              pass_done,
  output logic [ADDR_W:0]   word_count,
  output logic              timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT} state_t;

  localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(FIRST_ADDR);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(LAST_ADDR);

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   addr_nx;
  logic [ADDR_W:0]     wc_nx;
  logic                stop_pend, stop_pend_nx;
  logic                pd_nx;
  logic                terr_nx;
  logic                tmo_hit;
  logic                stopping;

`ifdef ADDR_SEQ_TIMEOUT_EN
  logic [9:0] tmo_cnt;

  // The counter holds 0 outside WAIT, so it restarts on every WAIT entry.
  // The hit fires at the end of the TIMEOUT-th WAIT cycle that has no word_done.
  assign tmo_hit = (state == S_WAIT) && !word_done && (tmo_cnt == 10'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || state != S_WAIT) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 10'd1;
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo = |TIMEOUT;
  assign tmo_hit    = 1'b0;
`endif

  // A stop that arrives in the same cycle as word_done applies at that boundary.
  assign stopping = stop_pend || stop;

  always_comb begin
    state_nx     = state;
    addr_nx      = addr;
    wc_nx        = word_count;
    stop_pend_nx = stop_pend;
    pd_nx        = 1'b0;
    terr_nx      = timeout_err;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nx     = S_LOAD;
          addr_nx      = FIRST;
          wc_nx        = '0;
          stop_pend_nx = 1'b0;
          terr_nx      = 1'b0;
        end
      end
      S_LOAD: begin
        state_nx = S_WAIT;
        if (stop) begin
          stop_pend_nx = 1'b1;
        end
      end
      S_WAIT: begin
        if (word_done || tmo_hit) begin
          // An abandoned word still advances the address, but it is not counted.
          if (word_done) begin
            wc_nx = word_count + (ADDR_W+1)'(1);
          end
          if (tmo_hit) begin
            terr_nx = 1'b1;
          end
          if (addr == LAST) begin
            pd_nx   = 1'b1;
            addr_nx = FIRST;
            if (loop && !stopping) begin
              wc_nx    = '0;
              state_nx = S_LOAD;
            end else begin
              state_nx = S_IDLE;
            end
          end else if (stopping) begin
            addr_nx  = FIRST;
            state_nx = S_IDLE;
          end else begin
            addr_nx  = addr + ADDR_W'(1);
            state_nx = S_LOAD;
          end
        end else if (stop) begin
          stop_pend_nx = 1'b1;
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // load and busy are taken from the next state. This keeps them registered
  // and aligned with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      addr        <= FIRST;
      load        <= 1'b0;
      busy        <= 1'b0;
      pass_done   <= 1'b0;
      word_count  <= '0;
      timeout_err <= 1'b0;
      stop_pend   <= 1'b0;
    end else begin
      state       <= state_nx;
      addr        <= addr_nx;
      load        <= (state_nx == S_LOAD);
      busy        <= (state_nx != S_IDLE);
      pass_done   <= pd_nx;
      word_count  <= wc_nx;
      timeout_err <= terr_nx;
      stop_pend   <= stop_pend_nx;
    end
  end

endmodule

// File: tb/tb_rom_addr_sequencer.sv
// tb/tb_rom_addr_sequencer.sv - self-checking bench for rom_addr_sequencer

module tb_rom_addr_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel = 1'b0;
  logic start = 1'b0, stop = 1'b0, loop_i = 1'b0, word_done = 1'b0;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  // Instance a runs a 0..31 pass. Instance b runs a 4..6 pass.
  logic       start_a, stop_a, loop_a, wd_a, start_b, stop_b, loop_b, wd_b;
  logic [4:0] addr_a, addr_b;
  logic       load_a, busy_a, pd_a, terr_a, load_b, busy_b, pd_b, terr_b;
  logic [5:0] wc_a, wc_b;

  assign start_a = sel ? 1'b0 : start;
  assign stop_a  = sel ? 1'b0 : stop;
  assign loop_a  = sel ? 1'b0 : loop_i;
  assign wd_a    = sel ? 1'b0 : word_done;
  assign start_b = sel ? start : 1'b0;
  assign stop_b  = sel ? stop : 1'b0;
  assign loop_b  = sel ? loop_i : 1'b0;
  assign wd_b    = sel ? word_done : 1'b0;

  logic [4:0] o_addr;
  logic       o_load, o_busy, o_pd, o_terr;
  logic [5:0] o_wc;
  assign o_addr = sel ? addr_b : addr_a;
  assign o_load = sel ? load_b : load_a;
  assign o_busy = sel ? busy_b : busy_a;
  assign o_pd   = sel ? pd_b : pd_a;
  assign o_terr = sel ? terr_b : terr_a;
  assign o_wc   = sel ? wc_b : wc_a;

  rom_addr_sequencer #(.ADDR_W(5), .FIRST_ADDR(0), .LAST_ADDR(31), .TIMEOUT(8)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .stop(stop_a), .loop(loop_a),
    .word_done(wd_a), .addr(addr_a), .load(load_a), .busy(busy_a),
    .pass_done(pd_a), .word_count(wc_a), .timeout_err(terr_a)
  );

  rom_addr_sequencer #(.ADDR_W(5), .FIRST_ADDR(4), .LAST_ADDR(6), .TIMEOUT(8)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .stop(stop_b), .loop(loop_b),
    .word_done(wd_b), .addr(addr_b), .load(load_b), .busy(busy_b),
    .pass_done(pd_b), .word_count(wc_b), .timeout_err(terr_b)
  );

  task automatic test_reset();
    logic [13:0] got;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      stop      = 1'($urandom_range(0, 1));
      word_done = 1'($urandom_range(0, 1));
      got = {o_addr, o_load, o_busy, o_pd, o_wc, o_terr};
      compared++;
      if (got !== 14'd0) begin
        mismatched++;
        $display("FAIL reset_idle cycle %0d: got %h want 0", i, got);
      end
    end
    stop      = 1'b0;
    word_done = 1'b0;
  endtask

  // Reference model. A pass visits first..last in order. At each completed
  // word the model decides to advance, wrap or end, using the pass rules.
  task automatic run_seq(input bit lp, input int stop_at, input int stop_pass,
                         input bit stop_same, input int rst_at, input int fix_dly,
                         input string name);
    int first, last, cur, passes, cd, dly;
    bit wd_prev, wd, stop_req, done, first_cyc, exp_load, exp_pd, rst_next, rst_pend;
    first = sel ? 4 : 0;
    last  = sel ? 6 : 31;
    cur = first; passes = 0; cd = -1;
    wd_prev = 0; stop_req = 0; done = 0; first_cyc = 1; rst_next = 0; rst_pend = 0;
    @(negedge clk);
    start  = 1'b1;
    loop_i = lp;
    for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
      @(negedge clk);
      if (rst_pend) begin
        rst = 1'b0;
        compared++;
        if ({o_addr, o_load, o_busy, o_pd, o_wc, o_terr} !== 14'd0) begin
          mismatched++;
          $display("FAIL %s mid_rst: got addr=%0d load=%0b busy=%0b pd=%0b wc=%0d terr=%0b want all 0",
                   name, o_addr, o_load, o_busy, o_pd, o_wc, o_terr);
        end
        done = 1;
        break;
      end
      exp_pd   = wd_prev && (cur == last);
      exp_load = first_cyc;
      if (wd_prev) begin
        if (cur == last) begin
          passes++;
          if (lp && !stop_req) begin cur = first; exp_load = 1; end
          else done = 1;
        end else if (stop_req) begin
          done = 1;
        end else begin
          cur++;
          exp_load = 1;
        end
      end
      compared++;
      if (o_pd !== exp_pd) begin
        mismatched++;
        $display("FAIL %s pass_done cyc %0d: got %0b want %0b", name, cyc, o_pd, exp_pd);
      end
      compared++;
      if (o_load !== exp_load) begin
        mismatched++;
        $display("FAIL %s load cyc %0d: got %0b want %0b", name, cyc, o_load, exp_load);
      end
      if (done) begin
        compared++;
        if (o_busy !== 1'b0 || o_addr !== 5'(first) || o_wc !== 6'(cur - first + 1) || o_terr !== 1'b0) begin
          mismatched++;
          $display("FAIL %s end_state: got busy=%0b addr=%0d wc=%0d terr=%0b want busy=0 addr=%0d wc=%0d terr=0",
                   name, o_busy, o_addr, o_wc, o_terr, first, cur - first + 1);
        end
      end else begin
        compared++;
        if (o_busy !== 1'b1) begin
          mismatched++;
          $display("FAIL %s busy cyc %0d: got %0b want 1", name, cyc, o_busy);
        end
        if (exp_load) begin
          compared++;
          if (o_addr !== 5'(cur) || o_wc !== 6'(cur - first)) begin
            mismatched++;
            $display("FAIL %s load_word: got addr=%0d wc=%0d want addr=%0d wc=%0d",
                     name, o_addr, o_wc, cur, cur - first);
          end
        end
      end
      if (done) break;
      first_cyc = 0;
      if (exp_load) begin
        dly = (fix_dly > 0) ? fix_dly : int'($urandom_range(1, 5));
        cd  = dly;
      end else begin
        cd--;
      end
      wd = (cd == 0);
      word_done = wd;
      start  = ($urandom_range(0, 3) == 0);
      loop_i = wd ? lp : 1'($urandom_range(0, 1));
      stop   = 1'b0;
      if (cur == stop_at && passes == stop_pass && !stop_req) begin
        if ((stop_same && wd) || (!stop_same && exp_load)) begin
          stop = 1'b1;
          stop_req = 1;
        end
      end
      if (rst_next) begin
        rst = 1'b1;
        rst_pend = 1;
      end
      if (exp_load && cur == rst_at) rst_next = 1;
      wd_prev = wd;
    end
    if (!done) begin
      compared++;
      mismatched++;
      $display("FAIL %s cycle_budget: sequence did not end, want end within 2000 cycles", name);
    end
    start = 1'b0; stop = 1'b0; loop_i = 1'b0; word_done = 1'b0; rst = 1'b0;
  endtask

  task automatic test_full_pass();
    sel = 1'b0;
    run_seq(1'b0, -1, 0, 1'b0, -1, 3, "full_pass");
  endtask

  task automatic test_loop();
    sel = 1'b1;
    run_seq(1'b1, 6, 1, 1'b0, -1, 0, "loop_two_pass");
  endtask

  task automatic test_stop();
    sel = 1'b0;
    run_seq(1'b0, 10, 0, 1'b1, -1, 0, "stop_same_cycle");
    sel = 1'b1;
    run_seq(1'b1, 4, 0, 1'b0, -1, 0, "stop_in_load");
  endtask

  task automatic test_rst_mid();
    sel = 1'b0;
    run_seq(1'b0, -1, 0, 1'b0, 7, 3, "rst_mid");
    run_seq(1'b0, -1, 0, 1'b0, -1, 0, "after_rst");
  endtask

  task automatic test_random();
    bit lp;
    int sa, sp;
    for (int i = 0; i < 4; i++) begin
      sel = 1'($urandom_range(0, 1));
      lp  = 1'($urandom_range(0, 1));
      sa  = sel ? int'($urandom_range(4, 6)) : int'($urandom_range(0, 31));
      sp  = lp ? int'($urandom_range(0, 1)) : 0;
      if (!lp && $urandom_range(0, 1) == 0) sa = -1;
      run_seq(lp, sa, sp, 1'($urandom_range(0, 1)), -1, 0, "random");
    end
  endtask

  task automatic test_timeout();
`ifdef ADDR_SEQ_TIMEOUT_EN
    sel = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      word_done = 1'b1;
      @(negedge clk);
      word_done = 1'b0;
    end
    compared++;
    if (o_load !== 1'b1 || o_addr !== 5'd2) begin
      mismatched++;
      $display("FAIL timeout_setup: got load=%0b addr=%0d want load=1 addr=2", o_load, o_addr);
    end
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      compared++;
      if (o_load !== 1'b0 || o_terr !== 1'b0) begin
        mismatched++;
        $display("FAIL timeout_wait %0d: got load=%0b terr=%0b want 0 0", i, o_load, o_terr);
      end
    end
    @(negedge clk);
    compared++;
    if (o_load !== 1'b1 || o_addr !== 5'd3 || o_terr !== 1'b1 || o_wc !== 6'd2) begin
      mismatched++;
      $display("FAIL timeout_fire: got load=%0b addr=%0d terr=%0b wc=%0d want 1 3 1 2",
               o_load, o_addr, o_terr, o_wc);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`endif
  endtask

  initial begin
    test_reset();
    test_full_pass();
    test_loop();
    test_stop();
    test_rst_mid();
    test_random();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
